// File: rtl/cp0_regfile_if.sv
// CP0 register file bus.
// Carries the write-back CP0 write request, the mfc0 read port, the committed
// exception from the memory stage, external interrupt lines and the
// architectural register views returned to the memory stage.
//   master : pipeline side, drives the requests and consumes the register views
//   slave  : CP0 side, consumes the requests and drives the register views
interface cp0_regfile_if;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [4:0]  raddr_i;
  logic [31:0] data_i;
  logic [5:0]  int_i;
  logic [31:0] excepttype_i;
  logic [31:0] cur_inst_addr_i;
  logic        is_in_delayslot_i;
  logic [31:0] data_o;
  logic [31:0] count_o;
  logic [31:0] compare_o;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic [31:0] config_o;
  logic [31:0] prid_o;
  logic        timer_int_o;

  modport master (
    output we_i, waddr_i, raddr_i, data_i, int_i,
    output excepttype_i, cur_inst_addr_i, is_in_delayslot_i,
    input  data_o, count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o,
    input  timer_int_o
  );

  modport slave (
    input  we_i, waddr_i, raddr_i, data_i, int_i,
    input  excepttype_i, cur_inst_addr_i, is_in_delayslot_i,
    output data_o, count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o,
    output timer_int_o
  );
endinterface

// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file.
// Holds Count/Compare/Status/Cause/EPC, the read-only PRId/Config, and the
// Count/Compare timer interrupt. Software writes come from write-back; the
// committed exception from the memory stage is applied on the same edge and
// overrides any overlapping software-written field.
// Ports:
//   clk  : clock, all state updates on rising edge
//   rst  : synchronous active-high reset
//   bus  : cp0_regfile_if slave (write/read ports, exception info, register views)
module cp0_regfile #(
  parameter logic [31:0] PRID_VALUE   = 32'h00480102,
  parameter logic [31:0] CONFIG_RESET = 32'h00008000
) (
  input  logic          clk,
  input  logic          rst,
  cp0_regfile_if.slave  bus
);

  localparam logic [4:0] RegCount   = 5'd9;
  localparam logic [4:0] RegCompare = 5'd11;
  localparam logic [4:0] RegStatus  = 5'd12;
  localparam logic [4:0] RegCause   = 5'd13;
  localparam logic [4:0] RegEpc     = 5'd14;
  localparam logic [4:0] RegPrid    = 5'd15;
  localparam logic [4:0] RegConfig  = 5'd16;

  localparam logic [31:0] StatusReset = 32'h10000000;

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic        timer_int_q, timer_int_d;

  logic        exc_take;
  logic [4:0]  exc_code;
  logic        exc_eret;

  // Decode committed exception into ExcCode.
  always_comb begin
    exc_take = 1'b0;
    exc_code = 5'd0;
    exc_eret = 1'b0;
    case (bus.excepttype_i)
      32'h0000_0001: begin exc_take = 1'b1; exc_code = 5'd0;  end
      32'h0000_0008: begin exc_take = 1'b1; exc_code = 5'd8;  end
      32'h0000_000a: begin exc_take = 1'b1; exc_code = 5'd10; end
      32'h0000_000d: begin exc_take = 1'b1; exc_code = 5'd13; end
      32'h0000_000c: begin exc_take = 1'b1; exc_code = 5'd12; end
      32'h0000_000e: exc_eret = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    count_d     = count_q + 32'd1;
    compare_d   = compare_q;
    status_d    = status_q;
    cause_d     = cause_q;
    epc_d       = epc_q;
    timer_int_d = timer_int_q;

    // Match uses the pre-increment Count; Compare of zero disables the timer.
    if ((compare_q != 32'd0) && (count_q == compare_q)) begin
      timer_int_d = 1'b1;
    end

    // Hardware interrupt lines are resampled every cycle.
    cause_d[15:10] = bus.int_i;

    if (bus.we_i) begin
      case (bus.waddr_i)
        RegCount:   count_d = bus.data_i;
        RegCompare: begin
          compare_d   = bus.data_i;
          timer_int_d = 1'b0;  // clear beats a same-cycle match
        end
        RegStatus:  status_d = bus.data_i;
        RegCause: begin
          cause_d[9:8]  = bus.data_i[9:8];
          cause_d[23:22] = bus.data_i[23:22];
        end
        RegEpc:     epc_d = bus.data_i;
        default: ;
      endcase
    end

    // Exception commit after the software write so it wins on overlap.
    if (exc_take) begin
      if (!status_q[1]) begin
        epc_d      = bus.is_in_delayslot_i ? (bus.cur_inst_addr_i - 32'd4)
                                           : bus.cur_inst_addr_i;
        cause_d[31] = bus.is_in_delayslot_i;
      end
      status_d[1]   = 1'b1;
      cause_d[6:2]  = exc_code;
    end else if (exc_eret) begin
      status_d[1] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= 32'd0;
      compare_q   <= 32'd0;
      status_q    <= StatusReset;
      cause_q     <= 32'd0;
      epc_q       <= 32'd0;
      timer_int_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      compare_q   <= compare_d;
      status_q    <= status_d;
      cause_q     <= cause_d;
      epc_q       <= epc_d;
      timer_int_q <= timer_int_d;
    end
  end

  // No write bypass: the memory stage forwards write-back data itself.
  always_comb begin
    case (bus.raddr_i)
      RegCount:   bus.data_o = count_q;
      RegCompare: bus.data_o = compare_q;
      RegStatus:  bus.data_o = status_q;
      RegCause:   bus.data_o = cause_q;
      RegEpc:     bus.data_o = epc_q;
      RegPrid:    bus.data_o = PRID_VALUE;
      RegConfig:  bus.data_o = CONFIG_RESET;
      default:    bus.data_o = 32'd0;
    endcase
  end

  assign bus.count_o     = count_q;
  assign bus.compare_o   = compare_q;
  assign bus.status_o    = status_q;
  assign bus.cause_o     = cause_q;
  assign bus.epc_o       = epc_q;
  assign bus.config_o    = CONFIG_RESET;
  assign bus.prid_o      = PRID_VALUE;
  assign bus.timer_int_o = timer_int_q;

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed bench for cp0_regfile: reset state, timer, Cause write masking,
// exception commit/eret, EXL behaviour and mid-run reset.
module tb_cp0_regfile;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  cp0_regfile_if bus ();

  cp0_regfile #(
    .PRID_VALUE   (32'h00480102),
    .CONFIG_RESET (32'h00008000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.we_i = 1'b1; bus.waddr_i = a; bus.data_i = d;
    tick();
    bus.we_i = 1'b0;
  endtask

  initial begin
    bus.we_i = 1'b0; bus.waddr_i = '0; bus.raddr_i = 5'd15; bus.data_i = '0;
    bus.int_i = '0; bus.excepttype_i = '0; bus.cur_inst_addr_i = '0;
    bus.is_in_delayslot_i = 1'b0;

    // Reset and idle run
    rst = 1'b1;
    #1;
    check("prid_read_in_reset", bus.data_o, 32'h00480102);
    tick();
    rst = 1'b0;
    check("count_reset", bus.count_o, 32'h0);
    check("cause_reset", bus.cause_o, 32'h0);
    check("epc_reset", bus.epc_o, 32'h0);
    check("compare_reset", bus.compare_o, 32'h0);
    repeat (5) tick();
    check("count_5", bus.count_o, 32'd5);
    check("status_reset", bus.status_o, 32'h10000000);
    check("config_reset", bus.config_o, 32'h00008000);
    check("timer_idle_cmp0", {31'b0, bus.timer_int_o}, 32'h0);
    check("prid_read", bus.data_o, 32'h00480102);
    check("prid_o", bus.prid_o, 32'h00480102);
    bus.raddr_i = 5'd16;
    #1 check("config_read", bus.data_o, 32'h00008000);
    bus.raddr_i = 5'd3;
    #1 check("unmapped_read", bus.data_o, 32'h0);

    // Timer: Compare=20 written at count 0
    rst = 1'b1; tick(); rst = 1'b0;
    wr(5'd11, 32'd20);
    check("compare_written", bus.compare_o, 32'd20);
    repeat (19) tick();
    check("count_at_20", bus.count_o, 32'd20);
    check("timer_before_match", {31'b0, bus.timer_int_o}, 32'h0);
    tick();
    check("timer_rises", {31'b0, bus.timer_int_o}, 32'h1);
    repeat (3) tick();
    check("timer_sticky", {31'b0, bus.timer_int_o}, 32'h1);
    wr(5'd11, 32'd100);
    check("timer_cleared", {31'b0, bus.timer_int_o}, 32'h0);
    // Count write overrides increment, then wraps
    wr(5'd9, 32'hFFFFFFFF);
    check("count_written", bus.count_o, 32'hFFFFFFFF);
    tick();
    check("count_wrap", bus.count_o, 32'h0);

    // Cause write masking
    bus.int_i = 6'b000011;
    wr(5'd13, 32'hFFFFFFFF);
    check("cause_masked", bus.cause_o, 32'h00C00F00);
    bus.raddr_i = 5'd13;
    #1 check("cause_read", bus.data_o, 32'h00C00F00);
    bus.int_i = 6'b0;
    wr(5'd15, 32'h0);
    check("cause_int_resampled", bus.cause_o, 32'h00C00300);
    bus.raddr_i = 5'd15;
    #1 check("prid_write_ignored", bus.data_o, 32'h00480102);

    // Syscall then eret
    bus.excepttype_i = 32'h8; bus.cur_inst_addr_i = 32'hBFC00100; bus.is_in_delayslot_i = 1'b0;
    tick();
    check("syscall_epc", bus.epc_o, 32'hBFC00100);
    check("syscall_status", bus.status_o, 32'h10000002);
    check("syscall_cause", bus.cause_o, 32'h00C00320);
    bus.excepttype_i = 32'he;
    tick();
    check("eret_status", bus.status_o, 32'h10000000);
    check("eret_epc", bus.epc_o, 32'hBFC00100);
    check("eret_cause", bus.cause_o, 32'h00C00320);
    bus.excepttype_i = 32'h0;

    // EXL=1: EPC and BD hold
    wr(5'd12, 32'h10000002);
    bus.excepttype_i = 32'hc; bus.cur_inst_addr_i = 32'h80000010; bus.is_in_delayslot_i = 1'b1;
    tick();
    check("exl_epc_hold", bus.epc_o, 32'hBFC00100);
    check("exl_cause", bus.cause_o, 32'h00C00330);
    check("exl_status", bus.status_o, 32'h10000002);
    bus.excepttype_i = 32'h5;
    tick();
    check("unknown_code_noop", bus.status_o, 32'h10000002);
    bus.excepttype_i = 32'he;
    tick();
    check("eret2_status", bus.status_o, 32'h10000000);

    // Same-cycle EPC write loses to exception (interrupt in delay slot)
    bus.excepttype_i = 32'h1;
    wr(5'd14, 32'h00001234);
    check("exc_beats_write_epc", bus.epc_o, 32'h8000000C);
    check("exc_bd_cause", bus.cause_o, 32'h80C00300);
    check("exc_int_status", bus.status_o, 32'h10000002);
    bus.excepttype_i = 32'h0; bus.is_in_delayslot_i = 1'b0;

    // Pending timer + EXL, then reset mid-count
    wr(5'd11, 32'd10);
    wr(5'd9, 32'd10);
    tick();
    check("timer_pending", {31'b0, bus.timer_int_o}, 32'h1);
    bus.int_i = 6'b101010;
    rst = 1'b1;
    bus.raddr_i = 5'd12;
    #1 check("status_read_during_rst", bus.data_o, 32'h10000002);
    tick();
    rst = 1'b0;
    check("rst_count", bus.count_o, 32'h0);
    check("rst_compare", bus.compare_o, 32'h0);
    check("rst_status", bus.status_o, 32'h10000000);
    check("rst_cause", bus.cause_o, 32'h0);
    check("rst_epc", bus.epc_o, 32'h0);
    check("rst_timer", {31'b0, bus.timer_int_o}, 32'h0);
    check("rst_config", bus.config_o, 32'h00008000);
    tick();
    check("count_restart", bus.count_o, 32'd1);
    check("cause_int_after_rst", bus.cause_o, 32'h0000A800);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cp0_regfile.md
Name: cp0_regfile

Overview:
- Coprocessor-0 register file.
- Directly downstream of the memory-access stage: consumes its committed exception type, faulting instruction address, delay-slot flag and the CP0 write request carried through mem/wb.
- Returns Status/Cause/EPC to that stage for interrupt and exception detection.
- Owns the free-running Count/Compare timer and the timer interrupt.

Parameters:
PRID_VALUE, 32'h00480102, read-only value of PRId (reg 15)
CONFIG_RESET, 32'h00008000, reset value of Config (reg 16; BE=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high; all registers act on rising edge of clk
we_i  in  1  CP0 write enable (from write-back)
waddr_i  in  5  CP0 write register number
raddr_i  in  5  CP0 read register number (mfc0)
data_i  in  32  CP0 write data
int_i  in  6  external hardware interrupt lines
excepttype_i  in  32  committed exception code from memory stage (0 = none)
cur_inst_addr_i  in  32  address of excepting instruction
is_in_delayslot_i  in  1  excepting instruction sits in a delay slot
data_o  out  32  combinational read data for raddr_i
count_o  out  32  Count (reg 9)
compare_o  out  32  Compare (reg 11)
status_o  out  32  Status (reg 12)
cause_o  out  32  Cause (reg 13)
epc_o  out  32  EPC (reg 14)
config_o  out  32  Config (reg 16)
prid_o  out  32  PRId (reg 15), constant PRID_VALUE
timer_int_o  out  1  timer interrupt, sticky until Compare written

Behaviour:
- Reset values on rst=1 at clock edge:
  - count_o=0, compare_o=0, status_o=32'h10000000 (CU0=1), cause_o=0, epc_o=0, config_o=CONFIG_RESET, timer_int_o=0.
  - data_o is combinational and follows raddr_i even during reset.
- Count increments by 1 every cycle; wraps 32'hFFFFFFFF -> 0.
- cause_o[15:10] <= int_i every cycle (one-cycle registered sample). Software writes never touch these bits.
- Timer interrupt:
  - At an edge where compare_o != 0 and count_o (pre-increment value) == compare_o, timer_int_o <= 1.
  - A Compare write clears timer_int_o on the same edge. The clear wins over a same-cycle match.
  - compare_o == 0 never raises the interrupt.
- Software write (we_i=1), applied at the edge:
  - 9: count_o <= data_i, overriding that cycle's increment.
  - 11: compare_o <= data_i.
  - 12: status_o <= data_i.
  - 13: only cause_o[9:8] (IP1:0), [22] (WP) and [23] (IV) updated.
  - 14: epc_o <= data_i.
  - 15 and 16: read-only, write ignored.
  - Any other address: ignored.
- Exception commit, evaluated after software write in the same edge; exception wins on any overlapping field.
  - For codes 32'h1 (interrupt, ExcCode 0), 32'h8 (syscall, 8), 32'ha (reserved instr, 10), 32'hd (trap, 13), 32'hc (overflow, 12):
    - If status_o[1] (EXL) == 0: epc_o <= is_in_delayslot_i ? cur_inst_addr_i-4 : cur_inst_addr_i, and cause_o[31] (BD) <= is_in_delayslot_i.
    - If EXL == 1: EPC and BD are unchanged.
    - In all cases status_o[1] <= 1 and cause_o[6:2] <= ExcCode.
  - 32'he (eret): status_o[1] <= 0. EPC and Cause are unchanged.
  - Any other nonzero code: no architectural effect.
- Read port: data_o = current register value for 9, 11, 12, 13, 14, 15, 16; 0 for all other addresses. No write bypass; the memory stage forwards write-back data itself.
- Unused bits of Cause/Status hold their last written value. No read-side masking.

Test Plan:
- Reset, then run 5 cycles with no stimulus -> count_o=5, status_o=32'h10000000, config_o=32'h00008000, timer_int_o=0, data_o(raddr=15)=32'h00480102.
- Write Compare=20 at count 0; hold -> timer_int_o rises on the edge after count_o==20 and stays 1; write Compare=100 -> timer_int_o=0 next cycle.
- Write Cause=32'hFFFFFFFF with int_i=6'b000011 -> cause_o=32'h00C00F00 (IP1:0, WP, IV, sampled IP7:2 only).
- excepttype_i=32'h8, cur_inst_addr_i=32'hBFC00100, delay slot 0 -> epc_o=32'hBFC00100, status_o[1]=1, cause_o[6:2]=8, cause_o[31]=0; then excepttype_i=32'he -> status_o[1]=0, epc unchanged.
- With EXL=1, excepttype_i=32'hc at 32'h80000010 in delay slot -> epc_o and BD unchanged, cause_o[6:2]=12; same-cycle software write EPC=32'h1234 plus exception with EXL=0 -> epc_o takes exception value.
- Assert rst mid-count with pending timer_int_o=1 and EXL=1 -> all outputs return to reset values on that edge; count restarts from 0 next cycle.
